// File: rtl/nic.sv
// Single-packet network interface: one router-to-processor buffer and one
// processor-to-router buffer, each with a full flag. Vectors are bit-0-MSB.
module nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr_nic,
  input  logic [0:63] din_to_nic,
  output logic [0:63] dout_from_nic,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  localparam logic [1:0] A_IN_BUF = 2'b00, A_IN_STAT = 2'b01,
                         A_OUT_BUF = 2'b10, A_OUT_STAT = 2'b11;

  logic [0:63] in_buf, out_buf;
  logic        in_full, out_full;
  logic        rd, wr;

  assign rd     = nicEn & ~nicWrEn;
  assign wr     = nicEn &  nicWrEn;
  assign net_ri = ~in_full;
  assign net_do = out_buf;
  // bit 0 of the packet is its VC; only the VC matching the router phase may go
  assign net_so = out_full & net_ro & (out_buf[0] == net_polarity);

  always_comb begin
    dout_from_nic = '0;
    if (rd) begin
      case (addr_nic)
        A_IN_BUF:   dout_from_nic = in_buf;
        A_IN_STAT:  dout_from_nic = {63'b0, in_full};
        A_OUT_BUF:  dout_from_nic = out_buf;
        A_OUT_STAT: dout_from_nic = {63'b0, out_full};
        default:    dout_from_nic = '0;
      endcase
    end
  end

  // Router fill only happens while empty, so it never races the read-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (net_si && !in_full) begin
      in_buf  <= net_di;
      in_full <= 1'b1;
    end else if (rd && addr_nic == A_IN_BUF && in_full) begin
      in_full <= 1'b0;
    end
  end

  // A write while full is dropped even if the buffer drains on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (wr && addr_nic == A_OUT_BUF && !out_full) begin
      out_buf  <= din_to_nic;
      out_full <= 1'b1;
    end else if (net_so) begin
      out_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nic.sv
// Directed bench for nic: router fill/drain, processor write/send, drops,
// simultaneous channel activity and asynchronous reset.
module tb_nic;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr_nic;
  logic [0:63] din_to_nic, dout_from_nic, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int checks = 0;
  int errors = 0;

  nic dut (
    .clk(clk), .reset(reset), .addr_nic(addr_nic), .din_to_nic(din_to_nic),
    .dout_from_nic(dout_from_nic), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di), .net_so(net_so),
    .net_ro(net_ro), .net_do(net_do), .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr_nic = a; #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr_nic = a; din_to_nic = d; #1;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr_nic = 2'b00; net_si = 1'b0; #1;
  endtask

  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] O1 = 64'h8000_0000_0000_0005;
  localparam logic [63:0] O2 = 64'hAAAA_0000_0000_0000;
  localparam logic [63:0] P3 = 64'h5555_0000_1111_2222;
  localparam logic [63:0] O3 = 64'h7000_0000_0000_0003;

  initial begin
    reset = 1'b0; addr_nic = 2'b00; din_to_nic = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    tick(); tick();
    chk("rst_ri", 64'(net_ri), 64'd1);
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_do", net_do, 64'd0);
    rd(2'b01); chk("rst_in_stat", dout_from_nic, 64'd0);
    rd(2'b11); chk("rst_out_stat", dout_from_nic, 64'd0);
    idle();
    #2 reset = 1'b1;

    // router packet in
    net_di = P1; net_si = 1'b1; tick(); idle();
    chk("fill_ri", 64'(net_ri), 64'd0);
    chk("idle_dout_zero", dout_from_nic, 64'd0);
    rd(2'b01); chk("fill_stat", dout_from_nic, 64'd1);
    rd(2'b00); chk("fill_data", dout_from_nic, P1);
    nicWrEn = 1'b1; #1; chk("wr_dout_zero", dout_from_nic, 64'd0);
    idle();

    // second packet while full is ignored
    net_di = PF; net_si = 1'b1; tick(); idle();
    rd(2'b00); chk("full_ignore", dout_from_nic, P1);
    tick(); idle();
    chk("clr_ri", 64'(net_ri), 64'd1);
    rd(2'b01); chk("clr_stat", dout_from_nic, 64'd0);
    rd(2'b00); chk("stale_data", dout_from_nic, P1);
    tick();
    chk("stale_ri", 64'(net_ri), 64'd1);
    wr(2'b00, PF); tick(); wr(2'b01, PF); tick(); wr(2'b11, PF); tick();
    rd(2'b00); chk("wr_in_ignored", dout_from_nic, P1);
    rd(2'b11); chk("wr_stat_ignored", dout_from_nic, 64'd0);
    idle();

    // processor write, VC gating, send
    net_ro = 1'b1; net_polarity = 1'b0;
    wr(2'b10, O1); tick(); idle();
    chk("vc_block_so", 64'(net_so), 64'd0);
    chk("out_do", net_do, O1);
    rd(2'b11); chk("out_stat", dout_from_nic, 64'd1);
    idle();
    net_polarity = 1'b1; #1;
    chk("vc_match_so", 64'(net_so), 64'd1);
    tick();
    rd(2'b11); chk("sent_stat", dout_from_nic, 64'd0);
    chk("sent_so", 64'(net_so), 64'd0);
    idle();

    // write while full is dropped
    net_ro = 1'b0;
    wr(2'b10, O2); tick();
    wr(2'b10, 64'h1); tick();
    rd(2'b10); chk("drop_buf", dout_from_nic, O2);
    rd(2'b11); chk("drop_stat", dout_from_nic, 64'd1);
    // drop even when the packet leaves on the same edge
    net_ro = 1'b1; net_polarity = 1'b1;
    wr(2'b10, 64'h2);
    chk("leave_so", 64'(net_so), 64'd1);
    tick();
    rd(2'b11); chk("leave_drop_stat", dout_from_nic, 64'd0);
    chk("leave_drop_do", net_do, O2);
    idle();

    // simultaneous fill and write
    net_ro = 1'b0;
    net_di = P3; net_si = 1'b1; wr(2'b10, O3); tick(); idle();
    rd(2'b01); chk("both_in_stat", dout_from_nic, 64'd1);
    rd(2'b11); chk("both_out_stat", dout_from_nic, 64'd1);
    rd(2'b00); chk("both_in_data", dout_from_nic, P3);
    chk("both_do", net_do, O3);
    idle();

    // asynchronous reset between edges
    net_ro = 1'b1; net_polarity = 1'b0; #1;
    chk("pre_rst_so", 64'(net_so), 64'd1);
    reset = 1'b0; #1;
    chk("arst_ri", 64'(net_ri), 64'd1);
    chk("arst_so", 64'(net_so), 64'd0);
    chk("arst_do", net_do, 64'd0);
    rd(2'b01); chk("arst_in_stat", dout_from_nic, 64'd0);
    rd(2'b11); chk("arst_out_stat", dout_from_nic, 64'd0);
    rd(2'b00); chk("arst_in_data", dout_from_nic, 64'd0);
    idle();

    // release and accept on first edge
    reset = 1'b1; net_di = PF; net_si = 1'b1; tick(); idle();
    rd(2'b00); chk("post_rst_data", dout_from_nic, PF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
